// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner: latches display data on Load,
// swaps it in only at frame boundaries, and drives one digit per slot with active-low anodes.
module seven_seg_scanner #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned GUARD    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [15:0] Value,
    input  logic [3:0]  DPIn,
    input  logic        LZB,
    output logic [3:0]  Hex,
    output logic        DP,
    output logic [3:0]  Anode,
    output logic        Busy,
    output logic        FrameDone
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    digit, digit_nxt;
    logic [15:0]   pend_val, pend_val_nxt, act_val, act_val_nxt;
    logic [3:0]    pend_dp, pend_dp_nxt, act_dp, act_dp_nxt;
    logic          pend_lzb, pend_lzb_nxt, act_lzb, act_lzb_nxt;
    logic          pending_nxt;
    logic          slot_end, boundary;
    logic [3:0]    blank_nxt;
    logic [3:0]    hex_nxt;
    logic [3:0]    anode_nxt;

    // Slot/digit sequencing; a frame boundary is the edge where digit wraps 3 -> 0
    always_comb begin
        slot_end  = (cnt == CW'(PRESCALE - 1));
        boundary  = slot_end && (digit == 2'd3);
        cnt_nxt   = slot_end ? '0 : cnt + CW'(1);
        digit_nxt = slot_end ? digit + 2'd1 : digit;
    end

    // Pending/active data movement; a Load on the boundary edge bypasses pending
    always_comb begin
        pend_val_nxt = pend_val;
        pend_dp_nxt  = pend_dp;
        pend_lzb_nxt = pend_lzb;
        pending_nxt  = Busy;
        act_val_nxt  = act_val;
        act_dp_nxt   = act_dp;
        act_lzb_nxt  = act_lzb;
        if (boundary) begin
            pending_nxt = 1'b0;
            if (Load) begin
                act_val_nxt = Value;
                act_dp_nxt  = DPIn;
                act_lzb_nxt = LZB;
            end else if (Busy) begin
                act_val_nxt = pend_val;
                act_dp_nxt  = pend_dp;
                act_lzb_nxt = pend_lzb;
            end
        end else if (Load) begin
            pend_val_nxt = Value;
            pend_dp_nxt  = DPIn;
            pend_lzb_nxt = LZB;
            pending_nxt  = 1'b1;
        end
    end

    // Leading-zero blanking and output selection from the next-cycle active data
    always_comb begin
        blank_nxt    = 4'b0000;
        blank_nxt[3] = act_lzb_nxt && (act_val_nxt[15:12] == 4'h0);
        blank_nxt[2] = blank_nxt[3] && (act_val_nxt[11:8] == 4'h0);
        blank_nxt[1] = blank_nxt[2] && (act_val_nxt[7:4] == 4'h0);

        case (digit_nxt)
            2'd0:    hex_nxt = act_val_nxt[3:0];
            2'd1:    hex_nxt = act_val_nxt[7:4];
            2'd2:    hex_nxt = act_val_nxt[11:8];
            default: hex_nxt = act_val_nxt[15:12];
        endcase

        if ((32'(cnt_nxt) < GUARD) || blank_nxt[digit_nxt])
            anode_nxt = 4'b1111;
        else
            anode_nxt = ~(4'b0001 << digit_nxt);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt       <= '0;
            digit     <= 2'd0;
            pend_val  <= 16'h0000;
            pend_dp   <= 4'h0;
            pend_lzb  <= 1'b0;
            act_val   <= 16'h0000;
            act_dp    <= 4'h0;
            act_lzb   <= 1'b0;
            Hex       <= 4'h0;
            DP        <= 1'b0;
            Anode     <= 4'b1111;
            Busy      <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            digit     <= digit_nxt;
            pend_val  <= pend_val_nxt;
            pend_dp   <= pend_dp_nxt;
            pend_lzb  <= pend_lzb_nxt;
            act_val   <= act_val_nxt;
            act_dp    <= act_dp_nxt;
            act_lzb   <= act_lzb_nxt;
            Hex       <= hex_nxt;
            DP        <= act_dp_nxt[digit_nxt];
            Anode     <= anode_nxt;
            Busy      <= pending_nxt;
            FrameDone <= boundary;
        end
    end

endmodule
